// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_pkg : shared defaults, width helper and status bundle for     |
// |                 sync_fifo_flags.                                         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sync_fifo_pkg;

   localparam int DEF_F_WIDTH = 8;
   localparam int DEF_F_DEPTH = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   typedef struct packed {
      logic full;
      logic half_full;
      logic almost_full;
      logic empty;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_mem : F_DEPTH x F_WIDTH storage, synchronous write port and   |
// |                 asynchronous read port. No reset on the array.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo_mem #(
   parameter int F_WIDTH = 8,
   parameter int F_DEPTH = 16,
   parameter int AW      = 4
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [F_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]      rd_addr,
   output logic [F_WIDTH-1:0] rd_data
);

   logic [F_WIDTH-1:0] mem_q [F_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_flags : single-clock FIFO with level/almost flags, occupancy, |
// |                   flush and sticky error flags. SYNC_FIFO_FWFT_EN selects|
// |                   first-word-fall-through output instead of registered.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter  int F_WIDTH = DEF_F_WIDTH,
   parameter  int F_DEPTH = DEF_F_DEPTH,
   localparam int AW      = clog2(F_DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic [F_WIDTH-1:0] d_in,
   input  logic               w_en,
   input  logic               r_en,
   input  logic [AW:0]        af_level,
   input  logic [AW:0]        ae_level,
   output logic [F_WIDTH-1:0] d_out,
   output logic               d_out_valid,
   output logic [AW:0]        f_count,
   output logic               f_full_flag,
   output logic               f_half_full_flag,
   output logic               f_almost_full_flag,
   output logic               f_empty_flag,
   output logic               f_almost_empty_flag,
   output logic               f_overflow_flag,
   output logic               f_underflow_flag
);

   localparam logic [AW:0]   c_full_cnt   = (AW+1)'(F_DEPTH);
   localparam logic [AW:0]   c_half_cnt   = (AW+1)'(F_DEPTH / 2);
   localparam logic [AW:0]   c_one        = (AW+1)'(1);
   localparam logic [AW+1:0] c_depth_wide = (AW+2)'(F_DEPTH);

   logic [AW:0]        wptr_q, wptr_d;
   logic [AW:0]        rptr_q, rptr_d;
   logic [AW:0]        count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               wr_acc, rd_acc;
   logic [AW+1:0]      af_sum;
   logic [F_WIDTH-1:0] mem_rdata;
   fifo_status_t       status;

   // Flags come from the registered count; the almost compares are widened
   // so an oversized margin saturates the flag rather than wrapping.
   always_comb begin
      status              = '0;
      af_sum              = {1'b0, count_q} + {1'b0, af_level};
      status.full         = (count_q == c_full_cnt);
      status.half_full    = (count_q >= c_half_cnt);
      status.almost_full  = (af_sum >= c_depth_wide);
      status.empty        = (count_q == '0);
      status.almost_empty = ({1'b0, count_q} <= {1'b0, ae_level});
      status.overflow     = ovf_q;
      status.underflow    = unf_q;
   end

   assign wr_acc = w_en && !status.full  && !clr;
   assign rd_acc = r_en && !status.empty && !clr;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | (w_en & status.full);
      unf_d   = unf_q | (r_en & status.empty);
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + c_one;
         if (rd_acc) rptr_d = rptr_q + c_one;
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + c_one;
            2'b01:   count_d = count_q - c_one;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   sync_fifo_mem #(
      .F_WIDTH (F_WIDTH),
      .F_DEPTH (F_DEPTH),
      .AW      (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wptr_q[AW-1:0]),
      .wr_data (d_in),
      .rd_addr (rptr_q[AW-1:0]),
      .rd_data (mem_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented directly; r_en only acknowledges it.
   assign d_out       = mem_rdata;
   assign d_out_valid = !status.empty;
`else
   logic [F_WIDTH-1:0] dout_q, dout_d;
   logic               dval_q, dval_d;

   always_comb begin
      dout_d = rd_acc ? mem_rdata : dout_q;
      dval_d = rd_acc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q <= '0;
         dval_q <= 1'b0;
      end else begin
         dout_q <= dout_d;
         dval_q <= dval_d;
      end
   end

   assign d_out       = dout_q;
   assign d_out_valid = dval_q;
`endif

   assign f_count             = count_q;
   assign f_full_flag         = status.full;
   assign f_half_full_flag    = status.half_full;
   assign f_almost_full_flag  = status.almost_full;
   assign f_empty_flag        = status.empty;
   assign f_almost_empty_flag = status.almost_empty;
   assign f_overflow_flag     = status.overflow;
   assign f_underflow_flag    = status.underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_fifo_flags : self-checking bench for sync_fifo_flags (16 x 8).  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sync_fifo_flags;

   localparam int W  = 8;
   localparam int D  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n, clr, w_en, r_en;
   logic [W-1:0]  d_in, d_out;
   logic [AW:0]   af_level, ae_level, f_count;
   logic          d_out_valid, f_full_flag, f_half_full_flag, f_almost_full_flag;
   logic          f_empty_flag, f_almost_empty_flag, f_overflow_flag, f_underflow_flag;

   int            n_checks = 0;
   int            n_fails  = 0;

   logic [W-1:0]  mq[$];
   logic [W-1:0]  sb[$];
   logic          m_ovf, m_unf;
   logic [W-1:0]  m_last;

   typedef struct {
      logic         w;
      logic         r;
      logic [W-1:0] din;
      int           cnt;
      logic         ovf;
      logic         unf;
      logic         dval;
      logic [W-1:0] dout;
   } vec_t;

   vec_t vecs[35];

   sync_fifo_flags #(.F_WIDTH(W), .F_DEPTH(D)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .clr                 (clr),
      .d_in                (d_in),
      .w_en                (w_en),
      .r_en                (r_en),
      .af_level            (af_level),
      .ae_level            (ae_level),
      .d_out               (d_out),
      .d_out_valid         (d_out_valid),
      .f_count             (f_count),
      .f_full_flag         (f_full_flag),
      .f_half_full_flag    (f_half_full_flag),
      .f_almost_full_flag  (f_almost_full_flag),
      .f_empty_flag        (f_empty_flag),
      .f_almost_empty_flag (f_almost_empty_flag),
      .f_overflow_flag     (f_overflow_flag),
      .f_underflow_flag    (f_underflow_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_status(input string tag, input int cnt, input logic ovf, input logic unf);
      chk({tag, ":count"}, f_count,             cnt);
      chk({tag, ":full"},  f_full_flag,         cnt == D);
      chk({tag, ":half"},  f_half_full_flag,    cnt >= D / 2);
      chk({tag, ":af"},    f_almost_full_flag,  cnt + int'(af_level) >= D);
      chk({tag, ":empty"}, f_empty_flag,        cnt == 0);
      chk({tag, ":ae"},    f_almost_empty_flag, cnt <= int'(ae_level));
      chk({tag, ":ovf"},   f_overflow_flag,     ovf);
      chk({tag, ":unf"},   f_underflow_flag,    unf);
   endtask

   task automatic chk_reset(input string tag);
      chk_status(tag, 0, 1'b0, 1'b0);
      chk({tag, ":dval"}, d_out_valid, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      chk({tag, ":dout"}, d_out, 8'h00);
`endif
   endtask

   // One clock of stimulus; the queue model decides acceptance from its
   // pre-edge occupancy and popped words go to the scoreboard.
   task automatic step(input logic w, input logic r, input logic c,
                       input logic [W-1:0] din, input string tag);
      logic m_full, m_empty, exp_v;
      @(negedge clk);
      w_en = w; r_en = r; clr = c; d_in = din;
      m_full  = (mq.size() == D);
      m_empty = (mq.size() == 0);
      @(posedge clk);
      #1;
      exp_v = 1'b0;
      if (c) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (w && m_full)  m_ovf = 1'b1;
         if (r && m_empty) m_unf = 1'b1;
         if (r && !m_empty) begin
            m_last = mq.pop_front();
            sb.push_back(m_last);
            exp_v = 1'b1;
         end
         if (w && !m_full) mq.push_back(din);
      end
      chk_status(tag, mq.size(), m_ovf, m_unf);
`ifdef SYNC_FIFO_FWFT_EN
      sb.delete();
      chk({tag, ":dval"}, d_out_valid, mq.size() > 0);
      if (mq.size() > 0) chk({tag, ":dout"}, d_out, mq[0]);
`else
      chk({tag, ":dval"}, d_out_valid, exp_v);
      if (d_out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s:sb_underrun: got valid with %0h, expected no word", tag, d_out);
         end else begin
            chk({tag, ":dout"}, d_out, sb.pop_front());
         end
      end else begin
         chk({tag, ":dout_hold"}, d_out, m_last);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      string tag;
      reset_n = 1'b1; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; d_in = '0;
      af_level = 5'd2; ae_level = 5'd2;
      m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;

      for (int i = 0; i < 16; i++)
         vecs[i] = '{1'b1, 1'b0, 8'(2 * i + 1), i + 1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[16] = '{1'b1, 1'b0, 8'd33, 16, 1'b1, 1'b0, 1'b0, 8'h00};
      for (int k = 0; k < 16; k++)
         vecs[17 + k] = '{1'b0, 1'b1, 8'h00, 15 - k, 1'b1, 1'b0, 1'b1, 8'(2 * k + 1)};
      vecs[33] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'd31};
      vecs[34] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'd31};

      #1 reset_n = 1'b0;
      #2 chk_reset("reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

`ifndef SYNC_FIFO_FWFT_EN
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         w_en = vecs[i].w; r_en = vecs[i].r; clr = 1'b0; d_in = vecs[i].din;
         @(posedge clk);
         #1;
         tag = $sformatf("vec%0d", i);
         chk_status(tag, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
         chk({tag, ":dval"}, d_out_valid, vecs[i].dval);
         chk({tag, ":dout"}, d_out, vecs[i].dout);
      end
      mq.delete();
      m_ovf = 1'b1; m_unf = 1'b1; m_last = 8'd31;
`endif

      step(1'b0, 1'b0, 1'b1, 8'h00, "clr0");

      for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), $sformatf("prefill%0d", i));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i), $sformatf("stream%0d", i));
      for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("drain%0d", i));

      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i), $sformatf("fill%0d", i));
      step(1'b1, 1'b1, 1'b0, 8'hEE, "full_wr_rd");

      step(1'b0, 1'b0, 1'b1, 8'h00, "clr1");
      step(1'b1, 1'b1, 1'b0, 8'h5A, "empty_wr_rd");

      // Threshold changes act between edges, with the count sitting at 1.
      @(negedge clk);
      w_en = 1'b0; r_en = 1'b0;
      ae_level = 5'd0;  #1 chk("thr_ae0", f_almost_empty_flag, 1'b0);
      ae_level = 5'd1;  #1 chk("thr_ae1", f_almost_empty_flag, 1'b1);
      ae_level = 5'd16; #1 chk("thr_ae16", f_almost_empty_flag, 1'b1);
      af_level = 5'd14; #1 chk("thr_af14", f_almost_full_flag, 1'b0);
      af_level = 5'd15; #1 chk("thr_af15", f_almost_full_flag, 1'b1);
      af_level = 5'd20; #1 chk("thr_af20", f_almost_full_flag, 1'b1);
      af_level = 5'd2; ae_level = 5'd2;
      #1 chk_status("thr_restore", 1, 1'b0, 1'b1);

      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), $sformatf("to10_%0d", i));
      step(1'b1, 1'b0, 1'b1, 8'h77, "clr_w");

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i), $sformatf("pre_rst%0d", i));
      #2 reset_n = 1'b0;
      #1 chk_reset("async_rst");
      w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      mq.delete(); sb.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
      step(1'b0, 1'b0, 1'b0, 8'h00, "post_rst");

`ifdef SYNC_FIFO_FWFT_EN
      step(1'b1, 1'b0, 1'b0, 8'hA5, "fwft_wr");
      chk("fwft_a5", d_out, 8'hA5);
      step(1'b0, 1'b1, 1'b0, 8'h00, "fwft_ack");
      chk("fwft_ack_valid", d_out_valid, 1'b0);
`else
      chk("sb_empty", sb.size(), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO for data buffering inside one clock domain.
- Successor to the team's dual-clock FIFO, keeping its flag set:
  - full
  - half-full
  - almost-full
  - empty
  - almost-empty
- Adds the following:
  - runtime-programmable almost thresholds
  - occupancy count output
  - synchronous flush
  - sticky overflow/underflow error flags
  - a registered-output read mode

Parameters:
- F_WIDTH, 8, data word width in bits (≥1).
- F_DEPTH, 16, number of entries; power of two, ≥4.
- AW, $clog2(F_DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties FIFO and clears error flags.
- d_in  input  F_WIDTH  write data.
- w_en  input  1  write request.
- r_en  input  1  read request.
- af_level  input  AW+1  almost-full margin; flag asserted when free slots ≤ af_level.
- ae_level  input  AW+1  almost-empty level; flag asserted when count ≤ ae_level.
- d_out  output  F_WIDTH  read data.
- d_out_valid  output  1  d_out holds a newly popped word.
- f_count  output  AW+1  current occupancy, 0..F_DEPTH.
- f_full_flag  output  1  count == F_DEPTH.
- f_half_full_flag  output  1  count ≥ F_DEPTH/2.
- f_almost_full_flag  output  1  count ≥ F_DEPTH − af_level.
- f_empty_flag  output  1  count == 0.
- f_almost_empty_flag  output  1  count ≤ ae_level.
- f_overflow_flag  output  1  sticky: write attempted while full.
- f_underflow_flag  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (reset_n low, async, any state):
  - pointers, f_count, d_out, d_out_valid, overflow, underflow = 0.
  - f_empty_flag = 1 and f_almost_empty_flag = 1 (count 0, since ae_level ≥ 0).
  - f_full_flag, f_half_full_flag and f_almost_full_flag = 0.
  - Release is taken on the next clk edge.
- Pointers are AW+1 bits:
  - the low AW bits address memory;
  - the MSB is the wrap bit;
  - they wrap naturally modulo 2·F_DEPTH.
- Write accepted iff w_en && !f_full_flag:
  - mem[wptr] ← d_in, wptr+1.
- Read accepted iff r_en && !f_empty_flag:
  - rptr+1.
- Flags are decoded from the registered f_count. They reflect a push or pop on the cycle after the accepting edge.
- Simultaneous accepted read and write:
  - f_count unchanged.
  - When full, only the read is accepted: f_count decrements and the write is dropped.
  - When empty, only the write is accepted.
- Overflow: w_en && f_full_flag sets f_overflow_flag; data is dropped and state is unchanged.
- Underflow: r_en && f_empty_flag sets f_underflow_flag; d_out holds and d_out_valid = 0.
- Standard mode (FWFT off):
  - d_out is registered from mem[rptr] on the accepting edge.
  - Latency is 1 clk from r_en sampled to data.
  - d_out_valid pulses high for exactly that one cycle per accepted read.
  - d_out holds its last value otherwise.
- Almost thresholds:
  - Compares are unsigned, widened to AW+2 bits.
  - af_level > F_DEPTH clamps the comparison to count ≥ 0, so the flag is always 1.
  - ae_level ≥ F_DEPTH means the flag is always 1.
  - Threshold changes take effect combinationally on the flags.
- clr:
  - Has priority over concurrent w_en/r_en in the same cycle; both are ignored.
  - Pointers, f_count and errors are set to 0; d_out_valid = 0; d_out holds.
  - Memory contents are not cleared.
- Memory has no reset; only pointers and control are reset.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - d_out = mem[rptr] combinationally whenever count > 0.
  - d_out_valid = !f_empty_flag.
  - r_en acts as an acknowledge, advancing to the next word.
  - Zero read latency: a word written at edge N appears on d_out after edge N (flag-delayed).
- Undefined: standard registered mode as above.
- Flag, count and error semantics are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - constants for the default F_WIDTH and F_DEPTH;
  - a function clog2 for the AW derivation;
  - a typedef fifo_status_t packing the five level flags plus the two error flags, for consumers that bundle status.
- One sub-module, sync_fifo_mem:
  - dual-port storage array with one write port and one read port, sized F_DEPTH × F_WIDTH;
  - synchronous write, read port asynchronous;
  - the top registers the output in standard mode.
- Pointer, count and flag logic stays in the top.

Test Plan (F_WIDTH=8, F_DEPTH=16, af_level=2, ae_level=2):
- Reset then 16 writes of 1,3,5,…,31 → after the 14th write f_almost_full_flag=1; after the 8th f_half_full_flag=1; after the 16th f_full_flag=1 and f_count=16; a 17th write sets f_overflow_flag=1 and f_count stays 16.
- From full, 16 reads (standard mode) → d_out=1,3,…,31, each 1 clk after its r_en with a single-cycle d_out_valid; f_almost_empty_flag=1 once count ≤2; f_empty_flag=1 at the end; an extra read sets f_underflow_flag=1 and d_out stays 31.
- Hold w_en=r_en=1 at count=8 for 40 cycles with incrementing data → f_count stays 8, data out in order, pointers wrap past 2·F_DEPTH with no corruption.
- Simultaneous w_en and r_en at full → read accepted, write dropped, f_count=15, f_overflow_flag=1; at empty → write accepted, read ignored, f_count=1, f_underflow_flag=1.
- Assert clr with count=10 and w_en=1 → next cycle f_count=0, f_empty_flag=1, both error flags 0; assert reset_n=0 mid-stream asynchronously → all outputs take their reset values before the next clk edge.
- SYNC_FIFO_FWFT_EN defined: write 0xA5 into an empty FIFO → d_out=0xA5 and d_out_valid=1 with no r_en; r_en for 1 cycle → d_out_valid=0, f_empty_flag=1.
